// File: rtl/reg_file_sb_if.sv
// Command/response bundle for the scoreboarded register file.
// The master drives the requests and the slave returns the registered read results.
interface reg_file_sb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  READY;
    logic                  READ;
    logic [ADDR_WIDTH-1:0] ADDR_R1;
    logic [ADDR_WIDTH-1:0] ADDR_R2;
    logic [DATA_WIDTH-1:0] DATA_R1;
    logic [DATA_WIDTH-1:0] DATA_R2;
    logic                  BUSY_R1;
    logic                  BUSY_R2;
    logic                  VALID_R;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] ADDR_W;
    logic [DATA_WIDTH-1:0] DATA_W;
    logic                  RESERVE;
    logic [ADDR_WIDTH-1:0] ADDR_RSV;

    modport master (
        input  READY, DATA_R1, DATA_R2, BUSY_R1, BUSY_R2, VALID_R,
        output READ, ADDR_R1, ADDR_R2, WRITE, ADDR_W, DATA_W, RESERVE, ADDR_RSV
    );

    modport slave (
        output READY, DATA_R1, DATA_R2, BUSY_R1, BUSY_R2, VALID_R,
        input  READ, ADDR_R1, ADDR_R2, WRITE, ADDR_W, DATA_W, RESERVE, ADDR_RSV
    );
endinterface

// File: rtl/reg_file_sb.sv
// Dual-read, single-write register file with write-to-read bypass, an optional
// hardwired zero register, a per-register busy scoreboard, and a post-reset clear sweep.
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    reg_file_sb_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic [DEPTH-1:0]        sb_q, sb_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic                    wr_en, rsv_en;

    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_r1_q, data_r1_d;
    logic [DATA_WIDTH-1:0]   data_r2_q, data_r2_d;
    logic                    busy_r1_q, busy_r1_d;
    logic                    busy_r2_q, busy_r2_d;

    // Next-state, single array write port, scoreboard update and read result.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        sb_d      = sb_q;
        mem_we    = 1'b0;
        mem_wa    = sweep_q;
        mem_wd    = '0;
        wr_en     = 1'b0;
        rsv_en    = 1'b0;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        data_r1_d = data_r1_q;
        data_r2_d = data_r2_q;
        busy_r1_d = busy_r1_q;
        busy_r2_d = busy_r2_q;

        case (state_q)
            CLEAR: begin
                mem_we  = 1'b1;
                sweep_d = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                wr_en  = bus.WRITE   && !(ZERO_REG && bus.ADDR_W   == '0);
                rsv_en = bus.RESERVE && !(ZERO_REG && bus.ADDR_RSV == '0);
                if (wr_en) begin
                    mem_we           = 1'b1;
                    mem_wa           = bus.ADDR_W;
                    mem_wd           = bus.DATA_W;
                    sb_d[bus.ADDR_W] = 1'b0;
                end
                // Reserve applied after the write-clear so a same-cycle reservation wins.
                if (rsv_en) begin
                    sb_d[bus.ADDR_RSV] = 1'b1;
                end
                if (bus.READ) begin
                    valid_d   = 1'b1;
                    data_r1_d = (wr_en && bus.ADDR_W == bus.ADDR_R1) ? bus.DATA_W : mem[bus.ADDR_R1];
                    data_r2_d = (wr_en && bus.ADDR_W == bus.ADDR_R2) ? bus.DATA_W : mem[bus.ADDR_R2];
                    busy_r1_d = sb_d[bus.ADDR_R1];
                    busy_r2_d = sb_d[bus.ADDR_R2];
                    if (ZERO_REG && bus.ADDR_R1 == '0) begin
                        data_r1_d = '0;
                        busy_r1_d = 1'b0;
                    end
                    if (ZERO_REG && bus.ADDR_R2 == '0) begin
                        data_r2_d = '0;
                        busy_r2_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLEAR;
            sweep_q   <= '0;
            sb_q      <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_r1_q <= '0;
            data_r2_q <= '0;
            busy_r1_q <= 1'b0;
            busy_r2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            sb_q      <= sb_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            data_r1_q <= data_r1_d;
            data_r2_q <= data_r2_d;
            busy_r1_q <= busy_r1_d;
            busy_r2_q <= busy_r2_d;
        end
    end

    // Storage array has no reset so it can map onto a RAM macro.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign bus.READY   = ready_q;
    assign bus.VALID_R = valid_q;
    assign bus.DATA_R1 = data_r1_q;
    assign bus.DATA_R2 = data_r2_q;
    assign bus.BUSY_R1 = busy_r1_q;
    assign bus.BUSY_R2 = busy_r2_q;

endmodule
